// File: rtl/auth_seq_blk.sv
// auth_seq_blk: multi-byte key unlock, go/stop tracking and debounced rider-off power-down
// Ports: clk, rst_n (sync, active-low); rx_data/rdy byte stream from UART_rcv;
//   rider_off from load cells; clr_rdy consumes every byte; pwr_up power enable;
//   locked lockout active; auth_fail one-cycle pulse per key mismatch.
// Optional: define AUTH_LOCKOUT_EN to build the fail counter, lock timer and LOCKED state.
module auth_seq_blk #(
  parameter int KEY_LEN = 2,
  parameter logic [KEY_LEN*8-1:0] KEY = 16'h4B67,
  parameter logic [7:0] GO_CODE = 8'h67,
  parameter logic [7:0] STOP_CODE = 8'h73,
  parameter int OFF_DLY = 1024,
  parameter int FAIL_LIMIT = 3,
  parameter int LOCK_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rdy,
  input  logic       rider_off,
  output logic       clr_rdy,
  output logic       pwr_up,
  output logic       locked,
  output logic       auth_fail
);
  localparam int KW = $clog2(KEY_LEN) + 1;
  localparam int OW = $clog2(OFF_DLY) + 1;
  localparam logic [KW-1:0] K_LAST = KW'(KEY_LEN - 1);
  localparam logic [OW-1:0] O_LAST = OW'(OFF_DLY - 1);
  typedef enum logic [2:0] {ST_IDLE, ST_KEY, ST_LOCKED, ST_PWR1, ST_PWR2} state_t;
  state_t state;
  logic [KW-1:0] k;
  logic [OW-1:0] off_cnt;
  logic [KEY_LEN*8-1:0] key_sh;
  logic [7:0] key_byte;
  // k stays 0 in IDLE, so one compare covers both key byte 0 and byte k
  assign key_sh = KEY << {k, 3'b000};
  assign key_byte = key_sh[KEY_LEN*8-1 -: 8];
  assign clr_rdy = rdy & rst_n;
  assign pwr_up = (state == ST_PWR1) || (state == ST_PWR2);
`ifdef AUTH_LOCKOUT_EN
  localparam int FW = $clog2(FAIL_LIMIT) + 1;
  localparam int LW = $clog2(LOCK_CYCLES) + 1;
  localparam logic [FW-1:0] F_LAST = FW'(FAIL_LIMIT - 1);
  localparam logic [LW-1:0] L_LAST = LW'(LOCK_CYCLES - 1);
  logic [FW-1:0] fail_cnt;
  logic [LW-1:0] lock_cnt;
  assign locked = (state == ST_LOCKED);
`else
  assign locked = 1'b0 & (FAIL_LIMIT > 0) & (LOCK_CYCLES > 0);
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      k <= '0;
      off_cnt <= '0;
      auth_fail <= 1'b0;
`ifdef AUTH_LOCKOUT_EN
      fail_cnt <= '0;
      lock_cnt <= '0;
`endif
    end else begin
      auth_fail <= 1'b0;
      case (state)
        ST_IDLE, ST_KEY: if (rdy) begin
          if (rx_data == key_byte) begin
            k <= (k == K_LAST) ? '0 : k + 1'b1;
            state <= (k == K_LAST) ? ST_PWR1 : ST_KEY;
`ifdef AUTH_LOCKOUT_EN
            if (k == K_LAST) fail_cnt <= '0;
`endif
          end else begin
            auth_fail <= 1'b1;
            k <= '0;
`ifdef AUTH_LOCKOUT_EN
            state <= (fail_cnt == F_LAST) ? ST_LOCKED : ST_IDLE;
            fail_cnt <= (fail_cnt == F_LAST) ? '0 : fail_cnt + 1'b1;
`else
            state <= ST_IDLE;
`endif
          end
        end
`ifdef AUTH_LOCKOUT_EN
        ST_LOCKED: begin
          lock_cnt <= (lock_cnt == L_LAST) ? '0 : lock_cnt + 1'b1;
          if (lock_cnt == L_LAST) state <= ST_IDLE;
        end
`endif
        ST_PWR1: if (rdy && rx_data == STOP_CODE) state <= rider_off ? ST_IDLE : ST_PWR2;
        ST_PWR2: begin
          // GO takes priority over a simultaneous off-timer expiry
          if (rdy && rx_data == GO_CODE) begin
            state <= ST_PWR1;
            off_cnt <= '0;
          end else if (!rider_off) off_cnt <= '0;
          else if (off_cnt == O_LAST) begin
            state <= ST_IDLE;
            off_cnt <= '0;
          end else off_cnt <= off_cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: doc/auth_seq_blk.md
# auth_seq_blk

Parametrised rider-authentication controller, successor to the single-byte power-up FSM. It consumes bytes from the existing UART receiver and unlocks power only after a configurable multi-byte key sequence. It then tracks go/stop commands and debounces rider departure with a programmable delay before dropping `pwr_up`. Repeated bad keys can lock the block out for a fixed period. It sits between `UART_rcv` and the balance/motor enable logic.

## Interface
- `KEY_LEN`, 2: number of key bytes; minimum 1.
- `KEY`, 16'h4B67: key sequence, `KEY_LEN*8` bits; the most significant byte is expected first.
- `GO_CODE`, 8'h67: resume command, accepted in PWR2.
- `STOP_CODE`, 8'h73: stop command, accepted in PWR1.
- `OFF_DLY`, 1024: number of consecutive `rider_off` cycles in PWR2 before power-down; minimum 1.
- `FAIL_LIMIT`, 3: number of consecutive key failures that triggers lockout.
- `LOCK_CYCLES`, 4096: lockout duration, in clocks.
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `rx_data` in 8: received byte from `UART_rcv`.
- `rdy` in 1: byte valid, from `UART_rcv`.
- `rider_off` in 1: rider-absent indication from the load cells.
- `clr_rdy` out 1: byte consumed.
- `pwr_up` out 1: power enable.
- `locked` out 1: lockout active.
- `auth_fail` out 1: one-cycle pulse on a key mismatch.

## Operation
- States: IDLE, KEY (partial key received, index `k` from 1 to `KEY_LEN-1`), LOCKED, PWR1 (running), PWR2 (stop pending, rider still on).
- Byte consumption: `clr_rdy = rdy & rst_n`, combinational.
  - Every byte presented is consumed in the same cycle, in every state, including non-matching bytes and bytes arriving in LOCKED.
  - Upstream drops `rdy` on the following cycle.
- IDLE:
  - Byte equal to key byte 0 → KEY with `k=1`, or → PWR1 directly if `KEY_LEN=1`.
  - Any other byte → fail.
- KEY:
  - Byte equal to key byte `k` → `k+1`; the last byte → PWR1, and the fail counter clears.
  - Mismatch → fail, return to IDLE. The mismatched byte is not re-evaluated as key byte 0.
- Fail: `auth_fail` pulses and the fail counter increments. If the count reaches `FAIL_LIMIT` → LOCKED and the counter clears.
- LOCKED: the lock timer counts `LOCK_CYCLES` clocks, then → IDLE. Bytes are discarded and generate no `auth_fail`.
- PWR1:
  - `STOP_CODE` with `rider_off=1` → IDLE.
  - `STOP_CODE` with `rider_off=0` → PWR2.
  - Other bytes are ignored.
- PWR2:
  - `GO_CODE` → PWR1.
  - Off timer increments each cycle `rider_off=1` and clears when `rider_off=0`. When it reaches `OFF_DLY` consecutive cycles → IDLE.
  - Other bytes are ignored.
- Simultaneous `GO_CODE` and off-timer expiry in PWR2: GO wins, next state PWR1.
- The off timer clears on any exit from PWR2.
- Counter widths: `$clog2` of the respective limit plus 1. No counter wraps: each saturates or clears at its terminal value.
- `pwr_up` = state is PWR1 or PWR2.
- `locked` = state is LOCKED.
- Both outputs are decoded directly from the state flops.

## Timing
- Reset, when `rst_n=0` at a clock edge:
  - State → IDLE; all counters → 0.
  - Outputs `pwr_up=0`, `locked=0`, `auth_fail=0`; `clr_rdy=0` while `rst_n=0`.
- Reset mid-operation, including during LOCKED or a partial key, fully restarts the block.
- Unlock: the final key byte is consumed in cycle N. `pwr_up` rises at the edge ending cycle N and is high from cycle N+1.
- Stop or rider departure: `pwr_up` falls at the same edge that the state leaves PWR1/PWR2.
- Rider departure in PWR2: with `rider_off` rising in cycle M and held, `pwr_up` is low from cycle M+`OFF_DLY`.
- `auth_fail` is registered: high exactly in cycle N+1 for a mismatch consumed in cycle N.
- Lockout: `locked` is high for exactly `LOCK_CYCLES` cycles.

## Configuration
- `AUTH_LOCKOUT_EN` defined: fail counter, lock timer and LOCKED state are present, and behave as described above.
- `AUTH_LOCKOUT_EN` undefined: none of them are built.
  - `locked` is tied to 0; `FAIL_LIMIT` and `LOCK_CYCLES` are unused.
  - A mismatch still pulses `auth_fail` and returns to IDLE.

## Test plan
- Unlock: bytes 0x4B then 0x67 → `pwr_up=1` one cycle after the 0x67 is consumed; `clr_rdy` is asserted with each byte.
- Wrong key: 0x4B, 0x11 → one `auth_fail` pulse, state IDLE. A following 0x4B, 0x67 still unlocks.
- Lockout (`AUTH_LOCKOUT_EN`): three wrong keys → `locked=1` for exactly 4096 cycles. A correct key sent during lockout leaves `pwr_up=0`; a correct key sent after lockout unlocks.
- Stop paths from PWR1:
  - 0x73 with `rider_off=1` → `pwr_up=0` on the next cycle.
  - 0x73 with `rider_off=0` → PWR2 with `pwr_up` staying 1; then `rider_off=1` for 1023 cycles, a 1-cycle drop, and 1024 cycles → `pwr_up` falls only at the end of the 1024-cycle run.
- In PWR2, 0x67 arrives in the cycle the off timer expires → state PWR1 and `pwr_up` stays 1.
- Assert `rst_n=0` during PWR1 and during a partial key → next edge: `pwr_up=0`, `locked=0`; a full key is needed afterwards.
